sume_axi_ipif_mcs: RTL
======================

Name: sume_axi_ipif_mcs

Overview:
- Parametrised AXI4-Lite slave to IPIF-style register bus bridge; next generation of the single-CS bridge used in every osnt_sume register block.
- Adds:
  - N address-decoded chip selects
  - independent AW/W acceptance
  - read/write fairness
  - access timeout
  - SLVERR/DECERR responses
- Sits between the AXI-Lite interconnect and per-module register files (stats, tx/rx configuration).

Parameters:
- C_S_AXI_DATA_WIDTH, 32, data width; multiple of 8.
- C_S_AXI_ADDR_WIDTH, 32, address width.
- C_NUM_CS, 2, number of chip selects / address ranges (1..8).
- C_CS_BASEADDR, {32'h0000_1000,32'h0000_0000}, flat vector C_NUM_CS*ADDR_WIDTH; range i base at slice i.
- C_CS_HIGHADDR, {32'h0000_1FFF,32'h0000_0FFF}, flat vector; inclusive range i high.
- C_TIMEOUT, 256, cycles from CS assert to forced termination; 0 disables.

Ports:
- S_AXI_ACLK  in  1  single clock for all logic.
- S_AXI_ARESET  in  1  synchronous, active-high reset.
- S_AXI_AWADDR/AWVALID/AWREADY  in/in/out  ADDR/1/1  write address channel.
- S_AXI_WDATA/WSTRB/WVALID/WREADY  in/in/in/out  DATA/DATA/8/1/1  write data channel.
- S_AXI_BRESP/BVALID/BREADY  out/out/in  2/1/1  write response.
- S_AXI_ARADDR/ARVALID/ARREADY  in/in/out  ADDR/1/1  read address.
- S_AXI_RDATA/RRESP/RVALID/RREADY  out/out/out/in  DATA/2/1/1  read data.
- Bus2IP_Clk  out  1  = S_AXI_ACLK.
- Bus2IP_Resetn  out  1  = ~S_AXI_ARESET.
- Bus2IP_Addr  out  ADDR  full captured address.
- Bus2IP_CS  out  C_NUM_CS  one-hot select.
- Bus2IP_RNW  out  1  1 = read.
- Bus2IP_Data  out  DATA  write data.
- Bus2IP_BE  out  DATA/8  byte enables.
- IP2Bus_Data  in  DATA  read data, valid with RdAck.
- IP2Bus_RdAck, IP2Bus_WrAck, IP2Bus_Error  in  1 each  acks; Error sampled with ack.

Behaviour:
- Reset: all registered outputs 0; holds empty; state IDLE; priority flag = read. Reset mid-transfer aborts it, drops CS next edge, issues no response.
- States:
  - IDLE: accept transactions.
  - WR_XFER / RD_XFER: CS asserted, waiting for ack or timeout.
  - WR_RESP: BVALID held until BREADY.
  - RD_RESP: RVALID held until RREADY.
- Ready generation in IDLE:
  - AWREADY = ~aw_held; WREADY = ~w_held (combinational).
  - AW and W may arrive in either order or the same cycle; captured into holds.
  - ARREADY=1 only when both holds are empty and (prio==read or no AWVALID/WVALID).
  - When ARREADY=1, AWREADY=WREADY=0 that cycle.
  - All readies are 0 outside IDLE.
- Fairness: prio toggles to the other direction after each granted transaction.
- Decode: range i matches if base_i <= addr <= high_i; on overlap the lowest i wins.
- Write launch (both holds full, match): next cycle enter WR_XFER; CS[i]=1, RNW=0, Addr/Data/BE from holds.
- Read launch (AR handshake, match): next cycle enter RD_XFER; CS[i]=1, RNW=1, BE=0.
- Decode miss: no CS asserted. Next cycle BVALID/RVALID=1 with RESP=2'b11 (DECERR); RDATA=0.
- Ack handling:
  - Ack counted only in the matching XFER state; stray acks elsewhere are ignored.
  - On ack at edge M: CS=0 from M+1. BVALID (or RVALID with RDATA<=IP2Bus_Data) at M+1.
  - RESP = Error ? 2'b10 : 2'b00. Zero-wait ack (ack in first CS cycle) is legal.
- Timeout:
  - Counter clears on XFER entry and increments each XFER cycle.
  - At count == C_TIMEOUT-1 without ack: terminate with SLVERR; RDATA=0.
  - Ack in the same cycle wins over timeout.
- Response holds: BVALID/RVALID and RESP/RDATA stable until READY; return to IDLE on the handshake edge. Minimum one IDLE cycle between transactions.
- Counter width = clog2(C_TIMEOUT+1).

Decomposition:
- Shared package sume_axi_pkg:
  - RESP_OKAY/SLVERR/DECERR constants.
  - State encoding localparams.
  - clog2 function.
- One sub-module, sume_addr_decode: combinational range compare; returns one-hot hit and miss flag, parametrised by C_NUM_CS and the flat range vectors.
- FSM, holds and timeout stay in the top.

Test Plan:
- W at cycle 0, AW at cycle 3, addr 0x1004, data 0xA5A5_0001, WSTRB 0xF, WrAck two cycles after CS -> CS=2'b10 with Addr 0x1004, Data 0xA5A5_0001, BE 0xF; BRESP=00 one cycle after ack; BVALID holds 3 cycles while BREADY=0.
- Read 0x0008, RdAck+Data 0x1234_5678 in the first CS cycle -> CS=2'b01, RNW=1; RVALID next cycle with RDATA 0x1234_5678, RRESP=00.
- Read 0x8000 (unmapped) -> no CS pulse; RVALID one cycle after AR handshake, RRESP=11, RDATA=0.
- Write to 0x0000 with no ack, C_TIMEOUT=16 -> CS high exactly 16 cycles, then BRESP=10; a late WrAck afterwards is ignored.
- AR and AW+W valid in the same IDLE cycle, 4 back-to-back rounds -> grants alternate read, write, read, write.
- S_AXI_ARESET pulsed during RD_XFER -> CS=0 and RVALID=0 after the edge; the next read completes with OKAY.

Source files
------------

// File: rtl/sume_axi_pkg.sv
// Shared definitions for the AXI4-Lite to IPIF multi-chip-select bridge.
//   - AXI response codes (OKAY / SLVERR / DECERR)
//   - bridge FSM state encoding
//   - clog2 helper used to size the access-timeout counter
package sume_axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam int ST_W = 3;
    localparam logic [ST_W-1:0] ST_IDLE    = 3'd0;
    localparam logic [ST_W-1:0] ST_WR_XFER = 3'd1;
    localparam logic [ST_W-1:0] ST_RD_XFER = 3'd2;
    localparam logic [ST_W-1:0] ST_WR_RESP = 3'd3;
    localparam logic [ST_W-1:0] ST_RD_RESP = 3'd4;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/sume_addr_decode.sv
// Combinational address-range decoder.
//   addr_i : address to decode
//   hit_o  : one-hot select of the matching range (all zero on a miss)
//   miss_o : no range contains addr_i
// Range i spans [base_i, high_i] inclusive, taken from slice i of the flat
// parameter vectors. Overlapping ranges resolve to the lowest index.
module sume_addr_decode #(
    parameter int C_NUM_CS     = 2,
    parameter int C_ADDR_WIDTH = 32,
    parameter logic [C_NUM_CS*C_ADDR_WIDTH-1:0] C_CS_BASEADDR = '0,
    parameter logic [C_NUM_CS*C_ADDR_WIDTH-1:0] C_CS_HIGHADDR = '0
) (
    input  logic [C_ADDR_WIDTH-1:0] addr_i,
    output logic [C_NUM_CS-1:0]     hit_o,
    output logic                    miss_o
);

    logic found;

    always_comb begin
        hit_o = '0;
        found = 1'b0;
        for (int i = 0; i < C_NUM_CS; i++) begin
            if (!found &&
                addr_i >= C_CS_BASEADDR[i*C_ADDR_WIDTH +: C_ADDR_WIDTH] &&
                addr_i <= C_CS_HIGHADDR[i*C_ADDR_WIDTH +: C_ADDR_WIDTH]) begin
                hit_o[i] = 1'b1;
                found    = 1'b1;
            end
        end
        miss_o = ~found;
    end

endmodule

// File: rtl/sume_axi_ipif_mcs.sv
// AXI4-Lite slave to IPIF register-bus bridge with N address-decoded chip
// selects, independent AW/W capture, read/write fairness, access timeout and
// SLVERR/DECERR responses.
//   S_AXI_*    : AXI4-Lite slave (AW, W, B, AR, R channels)
//   Bus2IP_*   : registered IPIF request (Addr, one-hot CS, RNW, Data, BE)
//   IP2Bus_*   : IPIF completion (Data with RdAck, WrAck, Error with ack)
// Handshakes: a transfer happens on a rising edge where VALID and READY are
// both high; VALID/payload are held stable until then.
module sume_axi_ipif_mcs
    import sume_axi_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 32,
    parameter int C_NUM_CS           = 2,
    parameter logic [C_NUM_CS*C_S_AXI_ADDR_WIDTH-1:0] C_CS_BASEADDR = {32'h0000_1000, 32'h0000_0000},
    parameter logic [C_NUM_CS*C_S_AXI_ADDR_WIDTH-1:0] C_CS_HIGHADDR = {32'h0000_1FFF, 32'h0000_0FFF},
    parameter int C_TIMEOUT          = 256
) (
    input  logic                              S_AXI_ACLK,
    input  logic                              S_AXI_ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY,
    output logic                              Bus2IP_Clk,
    output logic                              Bus2IP_Resetn,
    output logic [C_S_AXI_ADDR_WIDTH-1:0]     Bus2IP_Addr,
    output logic [C_NUM_CS-1:0]               Bus2IP_CS,
    output logic                              Bus2IP_RNW,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     Bus2IP_Data,
    output logic [C_S_AXI_DATA_WIDTH/8-1:0]   Bus2IP_BE,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     IP2Bus_Data,
    input  logic                              IP2Bus_RdAck,
    input  logic                              IP2Bus_WrAck,
    input  logic                              IP2Bus_Error
);

    localparam int AW    = C_S_AXI_ADDR_WIDTH;
    localparam int DW    = C_S_AXI_DATA_WIDTH;
    localparam int SW    = C_S_AXI_DATA_WIDTH / 8;
    localparam int CNT_W = (clog2(C_TIMEOUT + 1) < 1) ? 1 : clog2(C_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = (C_TIMEOUT > 0) ? CNT_W'(C_TIMEOUT - 1) : '0;

    logic [ST_W-1:0]     state_q, state_d;
    logic                aw_held_q, w_held_q, prio_rd_q;
    logic [AW-1:0]       aw_addr_q;
    logic [DW-1:0]       wdata_q;
    logic [SW-1:0]       wstrb_q;
    logic [AW-1:0]       ip_addr_q;
    logic [C_NUM_CS-1:0] cs_q;
    logic                rnw_q;
    logic [DW-1:0]       ip_data_q;
    logic [SW-1:0]       be_q;
    logic                bvalid_q, rvalid_q;
    logic [1:0]          bresp_q, rresp_q;
    logic [DW-1:0]       rdata_q;
    logic [CNT_W-1:0]    cnt_q;

    logic                is_idle, arready, awready, wready;
    logic                wr_launch, xfer_ack, xfer_timeout, xfer_done;
    logic [1:0]          xfer_resp;
    logic [AW-1:0]       dec_addr;
    logic [C_NUM_CS-1:0] dec_hit;
    logic                dec_miss;

    assign is_idle   = (state_q == ST_IDLE);
    assign wr_launch = is_idle & aw_held_q & w_held_q;

    // A read can only be granted with both write holds empty, so a single
    // decoder serves both directions.
    assign dec_addr = arready ? S_AXI_ARADDR : aw_addr_q;

    sume_addr_decode #(
        .C_NUM_CS      (C_NUM_CS),
        .C_ADDR_WIDTH  (AW),
        .C_CS_BASEADDR (C_CS_BASEADDR),
        .C_CS_HIGHADDR (C_CS_HIGHADDR)
    ) u_decode (
        .addr_i (dec_addr),
        .hit_o  (dec_hit),
        .miss_o (dec_miss)
    );

    // Acks only count in the XFER state of the matching direction.
    assign xfer_ack     = ((state_q == ST_WR_XFER) & IP2Bus_WrAck) |
                          ((state_q == ST_RD_XFER) & IP2Bus_RdAck);
    assign xfer_timeout = (C_TIMEOUT != 0) && (cnt_q == CNT_LAST);
    assign xfer_done    = xfer_ack | xfer_timeout;
    // Ack wins over a simultaneous timeout.
    assign xfer_resp    = xfer_ack ? (IP2Bus_Error ? RESP_SLVERR : RESP_OKAY) : RESP_SLVERR;

    // State register
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) state_q <= ST_IDLE;
        else              state_q <= state_d;
    end

    // Next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (arready)        state_d = dec_miss ? ST_RD_RESP : ST_RD_XFER;
                else if (wr_launch) state_d = dec_miss ? ST_WR_RESP : ST_WR_XFER;
            end
            ST_WR_XFER: if (xfer_done)    state_d = ST_WR_RESP;
            ST_RD_XFER: if (xfer_done)    state_d = ST_RD_RESP;
            ST_WR_RESP: if (S_AXI_BREADY) state_d = ST_IDLE;
            ST_RD_RESP: if (S_AXI_RREADY) state_d = ST_IDLE;
            default:                      state_d = ST_IDLE;
        endcase
    end

    // Channel readies. ARREADY waits for an actual ARVALID so that a read
    // priority slot never blocks a lone write; when the read is taken the
    // write channels are held off for that cycle.
    always_comb begin
        arready = 1'b0;
        awready = 1'b0;
        wready  = 1'b0;
        if (is_idle) begin
            arready = S_AXI_ARVALID & ~aw_held_q & ~w_held_q &
                      (prio_rd_q | ~(S_AXI_AWVALID | S_AXI_WVALID));
            awready = ~aw_held_q & ~arready;
            wready  = ~w_held_q & ~arready;
        end
    end

    // Holds, IPIF request, responses and timeout counter
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            prio_rd_q <= 1'b1;
            aw_addr_q <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            ip_addr_q <= '0;
            cs_q      <= '0;
            rnw_q     <= 1'b0;
            ip_data_q <= '0;
            be_q      <= '0;
            bvalid_q  <= 1'b0;
            rvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            rresp_q   <= RESP_OKAY;
            rdata_q   <= '0;
            cnt_q     <= '0;
        end else begin
            if (S_AXI_AWVALID & awready) begin
                aw_held_q <= 1'b1;
                aw_addr_q <= S_AXI_AWADDR;
            end
            if (S_AXI_WVALID & wready) begin
                w_held_q <= 1'b1;
                wdata_q  <= S_AXI_WDATA;
                wstrb_q  <= S_AXI_WSTRB;
            end
            case (state_q)
                ST_IDLE: begin
                    if (arready) begin
                        prio_rd_q <= 1'b0;
                        ip_addr_q <= S_AXI_ARADDR;
                        rnw_q     <= 1'b1;
                        be_q      <= '0;
                        cs_q      <= dec_hit;
                        cnt_q     <= '0;
                        if (dec_miss) begin
                            rvalid_q <= 1'b1;
                            rresp_q  <= RESP_DECERR;
                            rdata_q  <= '0;
                        end
                    end else if (wr_launch) begin
                        prio_rd_q <= 1'b1;
                        aw_held_q <= 1'b0;
                        w_held_q  <= 1'b0;
                        ip_addr_q <= aw_addr_q;
                        ip_data_q <= wdata_q;
                        be_q      <= wstrb_q;
                        rnw_q     <= 1'b0;
                        cs_q      <= dec_hit;
                        cnt_q     <= '0;
                        if (dec_miss) begin
                            bvalid_q <= 1'b1;
                            bresp_q  <= RESP_DECERR;
                        end
                    end
                end
                ST_WR_XFER, ST_RD_XFER: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (xfer_done) begin
                        cs_q <= '0;
                        if (state_q == ST_WR_XFER) begin
                            bvalid_q <= 1'b1;
                            bresp_q  <= xfer_resp;
                        end else begin
                            rvalid_q <= 1'b1;
                            rresp_q  <= xfer_resp;
                            rdata_q  <= xfer_ack ? IP2Bus_Data : '0;
                        end
                    end
                end
                ST_WR_RESP: if (S_AXI_BREADY) bvalid_q <= 1'b0;
                ST_RD_RESP: if (S_AXI_RREADY) rvalid_q <= 1'b0;
                default: ;
            endcase
        end
    end

    assign S_AXI_AWREADY = awready;
    assign S_AXI_WREADY  = wready;
    assign S_AXI_ARREADY = arready;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RRESP   = rresp_q;
    assign S_AXI_RDATA   = rdata_q;
    assign Bus2IP_Clk    = S_AXI_ACLK;
    assign Bus2IP_Resetn = ~S_AXI_ARESET;
    assign Bus2IP_Addr   = ip_addr_q;
    assign Bus2IP_CS     = cs_q;
    assign Bus2IP_RNW    = rnw_q;
    assign Bus2IP_Data   = ip_data_q;
    assign Bus2IP_BE     = be_q;

endmodule
